// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: bundles the CPU native memory port, the loader/debug port and
// the single-port memory bus around rom_arbiter.
//   slave  - the arbiter's view (requests in, completions and memory bus out)
//   master - the requesters' and memory's view (the opposite directions)
interface rom_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic              cpu_valid;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [3:0]        cpu_wstrb;
  logic              cpu_ready;
  logic [31:0]       cpu_rdata;

  logic              ld_valid;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_wdata;
  logic              ld_ready;
  logic [31:0]       ld_rdata;

  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
    output cpu_ready, cpu_rdata,
    input  ld_valid, ld_we, ld_addr, ld_wdata,
    output ld_ready, ld_rdata,
    output mem_wen, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
    input  cpu_ready, cpu_rdata,
    output ld_valid, ld_we, ld_addr, ld_wdata,
    input  ld_ready, ld_rdata,
    input  mem_wen, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin sharing of a single-port 256x32 memory (registered
// read, one cycle latency) between the picoRV32 native port and a loader port.
// Each access runs IDLE -> ACC -> RESP; grant is decided only in IDLE and the
// port not served gets priority next time.
// Optional feature macro: ROM_ARB_RMW_EN -- partial CPU stores are done as a
// read-modify-write (IDLE -> RMW_RD -> MERGE -> ACC -> RESP). Without it,
// partial stores complete without writing memory.
module rom_arbiter #(
  parameter int ADDR_W     = 8,
  parameter bit RESET_PRIO = 1'b0
) (
  input logic          clk,
  input logic          resetn,
  rom_arbiter_if.slave bus
);

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_LD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACC    = 3'd1,
    RESP   = 3'd2
`ifdef ROM_ARB_RMW_EN
    ,
    RMW_RD = 3'd3,
    MERGE  = 3'd4
`endif
  } state_t;

  state_t            state_r, state_s;
  logic              grant_r, grant_s;
  logic              prio_r, prio_s;
  logic              mem_wen_r, mem_wen_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic [31:0]       mem_wdata_r, mem_wdata_s;
  logic              cpu_ready_r, cpu_ready_s;
  logic              ld_ready_r, ld_ready_s;
`ifdef ROM_ARB_RMW_EN
  logic [3:0]        strb_r, strb_s;
`endif

  logic [ADDR_W-1:0] cpu_word_s;
  logic              cpu_write_s;
  logic              cpu_full_s;
  logic              pick_cpu_s;
  logic              unused_s;

`ifdef ROM_ARB_RMW_EN
  // Per-byte merge: strobed bytes from the store data, the rest from memory.
  function automatic logic [31:0] merge_bytes(input logic [31:0] new_data,
                                              input logic [31:0] old_data,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    merged = 32'h0;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = strb[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
    end
    return merged;
  endfunction
`endif

  // CPU byte address folds to a word index; upper bits alias, low bits are byte lanes.
  assign cpu_word_s  = bus.cpu_addr[ADDR_W+1:2];
  assign unused_s    = ^{bus.cpu_addr[31:ADDR_W+2], bus.cpu_addr[1:0]};
  assign cpu_write_s = (bus.cpu_wstrb != 4'h0);
  assign cpu_full_s  = (bus.cpu_wstrb == 4'hF);
  assign pick_cpu_s  = bus.cpu_valid && (!bus.ld_valid || (prio_r == GNT_CPU));

  // Next-state and next-register values for the access sequencer.
  always_comb begin
    state_s     = state_r;
    grant_s     = grant_r;
    prio_s      = prio_r;
    mem_wen_s   = mem_wen_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    cpu_ready_s = 1'b0;
    ld_ready_s  = 1'b0;
`ifdef ROM_ARB_RMW_EN
    strb_s      = strb_r;
`endif
    case (state_r)
      IDLE: begin
        if (pick_cpu_s) begin
          grant_s     = GNT_CPU;
          mem_addr_s  = cpu_word_s;
          mem_wdata_s = bus.cpu_wdata;
`ifdef ROM_ARB_RMW_EN
          strb_s      = bus.cpu_wstrb;
          if (cpu_write_s && !cpu_full_s) begin
            mem_wen_s = 1'b0;
            state_s   = RMW_RD;
          end else begin
            mem_wen_s = cpu_write_s;
            state_s   = ACC;
          end
`else
          // Partial strobes are dropped: only a full-word store writes.
          mem_wen_s   = cpu_write_s && cpu_full_s;
          state_s     = ACC;
`endif
        end else if (bus.ld_valid) begin
          grant_s     = GNT_LD;
          mem_addr_s  = bus.ld_addr;
          mem_wdata_s = bus.ld_wdata;
          mem_wen_s   = bus.ld_we;
          state_s     = ACC;
        end else begin
          mem_wen_s   = 1'b0;
        end
      end
`ifdef ROM_ARB_RMW_EN
      RMW_RD: begin
        mem_wen_s = 1'b0;
        state_s   = MERGE;
      end
      MERGE: begin
        // mem_wdata_r still holds the latched store data here.
        mem_wdata_s = merge_bytes(mem_wdata_r, bus.mem_rdata, strb_r);
        mem_wen_s   = 1'b1;
        state_s     = ACC;
      end
`endif
      ACC: begin
        mem_wen_s = 1'b0;
        state_s   = RESP;
        if (grant_r == GNT_LD) begin
          ld_ready_s = 1'b1;
        end else begin
          cpu_ready_s = 1'b1;
        end
      end
      RESP: begin
        prio_s  = ~grant_r;
        state_s = IDLE;
      end
      default: begin
        mem_wen_s = 1'b0;
        state_s   = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Grant, priority, memory bus and completion registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant_r     <= GNT_CPU;
      prio_r      <= RESET_PRIO;
      mem_wen_r   <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= 32'h0;
      cpu_ready_r <= 1'b0;
      ld_ready_r  <= 1'b0;
`ifdef ROM_ARB_RMW_EN
      strb_r      <= 4'h0;
`endif
    end else begin
      grant_r     <= grant_s;
      prio_r      <= prio_s;
      mem_wen_r   <= mem_wen_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      cpu_ready_r <= cpu_ready_s;
      ld_ready_r  <= ld_ready_s;
`ifdef ROM_ARB_RMW_EN
      strb_r      <= strb_s;
`endif
    end
  end

  assign bus.mem_wen   = mem_wen_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.cpu_ready = cpu_ready_r;
  assign bus.ld_ready  = ld_ready_r;
  // Read data is steered only to the port completing this cycle.
  assign bus.cpu_rdata = cpu_ready_r ? bus.mem_rdata : 32'h0;
  assign bus.ld_rdata  = ld_ready_r  ? bus.mem_rdata : 32'h0;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed-vector bench for rom_arbiter with a 256x32
// registered-read memory model (read-before-write) on the memory bus.
module tb_rom_arbiter;

  logic clk;
  logic resetn;
  logic tb_clear;
  logic [31:0] mem [0:255];

  int n_checks;
  int n_errors;

  rom_arbiter_if #(.ADDR_W(8)) bus ();

  rom_arbiter #(.ADDR_W(8), .RESET_PRIO(1'b0)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: synchronous write, registered read of the old contents.
  always @(posedge clk) begin
    if (tb_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      bus.mem_rdata <= 32'h0;
    end else begin
      if (bus.mem_wen) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One CPU transaction starting from IDLE; lat = cycles from request to ready (0 = timeout).
  task automatic cpu_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata, output int lat);
    @(posedge clk); #1;
    bus.cpu_valid = 1'b1;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.cpu_wstrb = strb;
    lat = 0;
    rdata = 32'h0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.cpu_ready) begin
        lat = i;
        rdata = bus.cpu_rdata;
        break;
      end
    end
    bus.cpu_valid = 1'b0;
  endtask

  // One loader transaction starting from IDLE; lat = cycles from request to ready (0 = timeout).
  task automatic ld_xfer(input logic [7:0] addr, input logic we, input logic [31:0] wdata,
                         output logic [31:0] rdata, output int lat);
    @(posedge clk); #1;
    bus.ld_valid = 1'b1;
    bus.ld_we    = we;
    bus.ld_addr  = addr;
    bus.ld_wdata = wdata;
    lat = 0;
    rdata = 32'h0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.ld_ready) begin
        lat = i;
        rdata = bus.ld_rdata;
        break;
      end
    end
    bus.ld_valid = 1'b0;
  endtask

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int lat;
    int found;
    n_checks = 0;
    n_errors = 0;
    resetn   = 1'b0;
    tb_clear = 1'b1;
    bus.cpu_valid = 1'b0;
    bus.cpu_addr  = 32'h0;
    bus.cpu_wdata = 32'h0;
    bus.cpu_wstrb = 4'h0;
    bus.ld_valid  = 1'b0;
    bus.ld_we     = 1'b0;
    bus.ld_addr   = 8'h0;
    bus.ld_wdata  = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tb_clear = 1'b0;
    resetn   = 1'b1;

    // Preload words used by the streaming test.
    ld_xfer(8'h00, 1'b1, 32'hC0C00001, rd, lat);
    check_val("preload0_lat", lat, 32'd2);
    ld_xfer(8'h01, 1'b1, 32'h1D1D0002, rd, lat);
    check_val("preload1_lat", lat, 32'd2);

    // 1: reset held with both requests pending.
    @(posedge clk); #1;
    resetn = 1'b0;
    bus.cpu_valid = 1'b1; bus.cpu_addr = 32'h0; bus.cpu_wstrb = 4'h0;
    bus.ld_valid  = 1'b1; bus.ld_we = 1'b0;     bus.ld_addr = 8'h01;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_cpu_ready", bus.cpu_ready, 32'd0);
    check_val("rst_ld_ready", bus.ld_ready, 32'd0);
    check_val("rst_mem_wen", bus.mem_wen, 32'd0);
    check_val("rst_mem_addr", bus.mem_addr, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // 3: both held -> cpu, ld, cpu, ld, each ready a single-cycle pulse.
    for (int k = 0; k < 4; k++) begin
      found = 0;
      for (int i = 1; i <= 10; i++) begin
        @(posedge clk); #1;
        if (bus.cpu_ready || bus.ld_ready) begin
          found = i;
          break;
        end
      end
      check_val($sformatf("stream%0d_lat", k), found, 32'd2);
      check_val($sformatf("stream%0d_ld_granted", k), bus.ld_ready, (k % 2 == 1) ? 32'd1 : 32'd0);
      check_val($sformatf("stream%0d_rdata", k), bus.ld_ready ? bus.ld_rdata : bus.cpu_rdata,
                (k % 2 == 1) ? 32'h1D1D0002 : 32'hC0C00001);
      check_val($sformatf("stream%0d_other_rdata", k), bus.ld_ready ? bus.cpu_rdata : bus.ld_rdata, 32'h0);
      if (k == 3) begin
        bus.cpu_valid = 1'b0;
        bus.ld_valid  = 1'b0;
      end
      @(posedge clk); #1;
      check_val($sformatf("stream%0d_pulse", k), {bus.cpu_ready, bus.ld_ready}, 32'd0);
    end

    // 2: loader write then CPU read of the same word.
    ld_xfer(8'h10, 1'b1, 32'hAABBCCDD, rd, lat);
    check_val("t2_ld_wr_lat", lat, 32'd2);
    cpu_xfer(32'h00000040, 32'h0, 4'h0, rd, lat);
    check_val("t2_cpu_rd_lat", lat, 32'd2);
    check_val("t2_cpu_rdata", rd, 32'hAABBCCDD);

    // CPU full-word store, read back through the loader.
    cpu_xfer(32'h00000018, 32'h5A5A1234, 4'hF, rd, lat);
    check_val("full_wr_lat", lat, 32'd2);
    ld_xfer(8'h06, 1'b0, 32'h0, rd, lat);
    check_val("full_wr_ld_rdata", rd, 32'h5A5A1234);

    // 4: partial store of one byte.
    ld_xfer(8'h05, 1'b1, 32'h11223344, rd, lat);
    cpu_xfer(32'h00000014, 32'h000000EE, 4'b0001, rd, lat);
`ifdef ROM_ARB_RMW_EN
    check_val("t4_part_lat", lat, 32'd4);
`else
    check_val("t4_part_lat", lat, 32'd2);
`endif
    cpu_xfer(32'h00000014, 32'h0, 4'h0, rd, lat);
`ifdef ROM_ARB_RMW_EN
    check_val("t4_readback", rd, 32'h112233EE);
`else
    check_val("t4_readback", rd, 32'h11223344);
`endif

    // 5: reset during the ACC cycle of a loader write.
    @(posedge clk); #1;
    bus.ld_valid = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 8'h20; bus.ld_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    check_val("t5_wen_in_acc", bus.mem_wen, 32'd1);
    resetn = 1'b0;
    #1;
    check_val("t5_wen_after_rst", bus.mem_wen, 32'd0);
    bus.ld_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    ld_xfer(8'h20, 1'b0, 32'h0, rd, lat);
    check_val("t5_rd_lat", lat, 32'd2);
    check_val("t5_no_write", rd, 32'h0);

    // 6: high CPU address bits alias onto the word index.
    ld_xfer(8'h02, 1'b1, 32'h0202CAFE, rd, lat);
    cpu_xfer(32'hFFFFFC08, 32'h0, 4'h0, rd, lat);
    check_val("t6_alias_lat", lat, 32'd2);
    check_val("t6_alias_rdata", rd, 32'h0202CAFE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
